instruction_fetch_unit: RTL and testbench

//  Producer end of the PMEM->decoder instruction path. Keeps the PC and issues word reads to program memory.

---
 rtl/instruction_fetch_unit_pkg.sv | 17 +
 rtl/instruction_fetch_unit_fetch_fifo.sv | 73 +++++++
 rtl/instruction_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared constants for the instruction fetch path: the NOP word presented
//   to decode when nothing is valid, and the fetch FSM state encodings.
// ----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_RUN   = 2'd0,  // no read outstanding
    IFU_WAIT  = 2'd1,  // one live read outstanding
    IFU_FLUSH = 2'd2   // one stale read outstanding, response is dropped
  } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO holding {pc, instr} entries between program memory
//   and decode. Flush empties it in one cycle and wins over push/pop.
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   flush          drop all entries
//   push/push_data write one entry
//   pop            remove the head entry
//   head_data      current head entry (meaningless when empty)
//   empty/full     fill-level flags
//   count          number of stored entries
// ----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // a simultaneous pop frees a slot, so push is legal even when full
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: entries are only observed while counted
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   Keeps the PC, issues single-outstanding word reads to program memory,
//   buffers returned words with their PC and hands them to decode over a
//   valid/ready handshake. A redirect flushes the buffer, kills the head
//   combinationally and drops any in-flight read.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   pmem_req/addr/gnt        read request, held with addr until gnt
//   pmem_rvalid/rdata        read response, >=1 cycle after gnt
//   instr_valid/ready        decode handshake
//   instr, instr_pc          head word (NOP when invalid) and its PC
//   redirect_valid/pc        taken branch/jump: refetch from redirect_pc
//   fetch_misalign           sticky misaligned-redirect flag
//                            (only with IFU_MISALIGN_TRAP_EN defined)
// Build option: IFU_MISALIGN_TRAP_EN -- trap misaligned redirects instead
//   of silently aligning them.
// ----------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  INSTR_WIDTH  = 32,
  parameter int                  FIFO_DEPTH   = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   pmem_req,
  output logic [PC_WIDTH-1:0]    pmem_addr,
  input  logic                   pmem_gnt,
  input  logic                   pmem_rvalid,
  input  logic [INSTR_WIDTH-1:0] pmem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic                   fetch_misalign
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e              state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d, req_pc_q, req_pc_d, tgt_pc;
  logic                    active_q;
  logic                    trap;
  logic                    fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]           fifo_count;
  logic [PC_WIDTH-1:0]     head_pc;
  logic [INSTR_WIDTH-1:0]  head_instr;

`ifdef IFU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign tgt_pc         = redirect_pc;
  assign trap           = misalign_q;
  assign fetch_misalign = misalign_q;
  assign misalign_d     = redirect_valid ? (redirect_pc[1:0] != 2'b00) : misalign_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign tgt_pc = redirect_pc & ~PC_WIDTH'(3);
  assign trap   = 1'b0;
`endif

  // Nothing is in flight while in RUN, so fill level alone gates issue.
  // active_q holds off the first request until the cycle after reset.
  assign pmem_req    = active_q && (state_q == IFU_RUN) && (fifo_count < CW'(FIFO_DEPTH))
                       && !redirect_valid && !trap;
  assign pmem_addr   = pc_q;
  assign instr_valid = !fifo_empty && !redirect_valid && !trap;
  assign fifo_pop    = instr_valid && instr_ready;
  assign instr       = instr_valid ? head_instr : INSTR_WIDTH'(NOP_INSTR);
  assign instr_pc    = instr_valid ? head_pc : '0;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    fifo_push = 1'b0;
    case (state_q)
      IFU_RUN: begin
        if (pmem_req && pmem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_WIDTH'(4);
          state_d  = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (pmem_rvalid) begin
          fifo_push = !redirect_valid && !fifo_full;
          state_d   = IFU_RUN;
        end else if (redirect_valid) begin
          state_d = IFU_FLUSH;
        end
      end
      IFU_FLUSH: if (pmem_rvalid) state_d = IFU_RUN;
      default:   state_d = IFU_RUN;
    endcase
    if (redirect_valid) pc_d = tgt_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IFU_RUN;
      pc_q     <= RESET_VECTOR;
      req_pc_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      active_q <= 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH (PC_WIDTH + INSTR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data ({req_pc_q, pmem_rdata}),
    .pop       (fifo_pop),
    .head_data ({head_pc, head_instr}),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // a response with no read outstanding is a memory-side protocol error
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(state_q == IFU_RUN && pmem_rvalid))
    else $error("pmem_rvalid with no read outstanding");

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0 = 32'hA000_0001, I1 = 32'hA000_0002, I2 = 32'hA000_0003,
                          I3 = 32'hA000_0004, I4 = 32'hA000_0005, I5 = 32'hA000_0006,
                          I6 = 32'hA000_0007, I7 = 32'hA000_0008;

  logic        clk = 1'b0, rst = 1'b1;
  logic        pmem_req, pmem_gnt = 1'b0, pmem_rvalid = 1'b0;
  logic [31:0] pmem_addr, pmem_rdata = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  int n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pmem_req       (pmem_req),
    .pmem_addr      (pmem_addr),
    .pmem_gnt       (pmem_gnt),
    .pmem_rvalid    (pmem_rvalid),
    .pmem_rdata     (pmem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one read: request at address a is granted, data d returns next cycle
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
    check("issue_req", {31'd0, pmem_req}, 1);
    check("issue_addr", pmem_addr, a);
    pmem_gnt = 1'b1;
    tick;
    pmem_gnt = 1'b0;
    #1;
    check("wait_req", {31'd0, pmem_req}, 0);
    pmem_rvalid = 1'b1;
    pmem_rdata  = d;
    tick;
    pmem_rvalid = 1'b0;
    #1;
  endtask

  task automatic check_head(input logic [31:0] pc, input logic [31:0] d);
    check("head_valid", {31'd0, instr_valid}, 1);
    check("head_instr", instr, d);
    check("head_pc", instr_pc, pc);
  endtask

  initial begin
    // reset values
    #2;
    check("rst_req", {31'd0, pmem_req}, 0);
    check("rst_valid", {31'd0, instr_valid}, 0);
    check("rst_instr", instr, NOP);
    check("rst_pc", instr_pc, 0);
    check("rst_addr", pmem_addr, 0);
    tick;
    rst = 1'b0;
    #1;
    check("req_at_release", {31'd0, pmem_req}, 0);
    tick;

    // 1: streaming with 1-cycle memory
    instr_ready = 1'b1;
    fetch_one(32'h0, I0); check_head(32'h0, I0);
    fetch_one(32'h4, I1); check_head(32'h4, I1);
    fetch_one(32'h8, I2); check_head(32'h8, I2);

    // 2: decode stalls, buffer fills, drains in order
    instr_ready = 1'b0;
    fetch_one(32'hC, I3);
    check_head(32'h8, I2);
    check("full_req", {31'd0, pmem_req}, 0);
    repeat (10) tick;
    check("stall_req", {31'd0, pmem_req}, 0);
    check_head(32'h8, I2);
    instr_ready = 1'b1;
    #1;
    check_head(32'h8, I2);
    tick;
    check_head(32'hC, I3);
    check("drain_req", {31'd0, pmem_req}, 1);
    check("drain_addr", pmem_addr, 32'h10);
    tick;
    check("drained_valid", {31'd0, instr_valid}, 0);
    check("drained_instr", instr, NOP);

    // 3: redirect while a read is outstanding
    pmem_gnt = 1'b1;
    tick;
    pmem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("redir_req", {31'd0, pmem_req}, 0);
    tick;
    redirect_valid = 1'b0;
    #1;
    check("flush_req", {31'd0, pmem_req}, 0);
    pmem_rvalid = 1'b1;
    pmem_rdata  = 32'hDEAD_BEEF;
    tick;
    pmem_rvalid = 1'b0;
    #1;
    check("flush_drop", {31'd0, instr_valid}, 0);
    fetch_one(32'h100, I4);
    check_head(32'h100, I4);

    // 4: redirect coincides with rvalid and a pop
    instr_ready = 1'b0;
    pmem_gnt = 1'b1;
    tick;
    pmem_gnt = 1'b0;
    pmem_rvalid = 1'b1;
    pmem_rdata  = 32'hBAD0_0BAD;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    instr_ready = 1'b1;
    #1;
    check("kill_valid", {31'd0, instr_valid}, 0);
    check("kill_instr", instr, NOP);
    check("kill_req", {31'd0, pmem_req}, 0);
    tick;
    pmem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("post_kill_valid", {31'd0, instr_valid}, 0);
    check("post_kill_req", {31'd0, pmem_req}, 1);
    check("post_kill_addr", pmem_addr, 32'h200);
    fetch_one(32'h200, I5);
    check_head(32'h200, I5);

`ifdef IFU_MISALIGN_TRAP_EN
    // 6: misaligned redirect traps until a good redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick;
    redirect_valid = 1'b0;
    #1;
    check("mis_set", {31'd0, fetch_misalign}, 1);
    check("mis_req", {31'd0, pmem_req}, 0);
    check("mis_valid", {31'd0, instr_valid}, 0);
    tick;
    check("mis_sticky", {31'd0, fetch_misalign}, 1);
    check("mis_req2", {31'd0, pmem_req}, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h104;
    tick;
    redirect_valid = 1'b0;
    #1;
    check("mis_clr", {31'd0, fetch_misalign}, 0);
    fetch_one(32'h104, I6);
    check_head(32'h104, I6);
`else
    // misaligned redirect target is aligned down
    redirect_valid = 1'b1;
    redirect_pc = 32'h302;
    #1;
    check("align_req", {31'd0, pmem_req}, 0);
    check("align_valid", {31'd0, instr_valid}, 0);
    tick;
    redirect_valid = 1'b0;
    #1;
    check("align_addr", pmem_addr, 32'h300);
    fetch_one(32'h300, I6);
    check_head(32'h300, I6);
`endif

    // 5: PC wrap, then reset in the middle of a read
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect_valid = 1'b0;
    #1;
    fetch_one(32'hFFFF_FFFC, I7);
    check_head(32'hFFFF_FFFC, I7);
    check("wrap_addr", pmem_addr, 32'h0);
    pmem_gnt = 1'b1;
    tick;
    pmem_gnt = 1'b0;
    #1;
    check("pre_rst_addr", pmem_addr, 32'h4);
    rst = 1'b1;
    #1;
    check("mid_rst_addr", pmem_addr, 32'h0);
    check("mid_rst_instr", instr, NOP);
    check("mid_rst_valid", {31'd0, instr_valid}, 0);
    check("mid_rst_req", {31'd0, pmem_req}, 0);
    tick;
    rst = 1'b0;
    tick;
    check("restart_req", {31'd0, pmem_req}, 1);
    check("restart_addr", pmem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
